rom_prefetch_buffer: RTL and testbench

Byte prefetch window between the QSPI flash controller and the Atari 2600 cartridge bus. It turns the controller's continuous sequential read stream into a small ring buffer of consecutive ROM bytes. It serves CPU fetches that fall inside the window without stalling. On a true miss it stops the stream and restarts it at the new address.

---
 rtl/rom_prefetch_buffer_if.sv | 36 +++
 rtl/rom_prefetch_buffer.sv | 127 ++++++++++++
 tb/tb_rom_prefetch_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_prefetch_buffer_if
// Brief    : CPU-side ROM bus and QSPI stream handshake for the prefetch buffer
// Revision : 1.0 - initial release
// ============================================================================
interface rom_prefetch_buffer_if #(
   parameter int ADDR_BITS = 12
);
   logic                 rom_read;
   logic [ADDR_BITS-1:0] rom_address;
   logic [7:0]           rom_data;
   logic                 rom_wait;
   logic [ADDR_BITS-1:0] flash_addr;
   logic                 flash_start_read;
   logic                 flash_stop_read;
   logic                 flash_stall_read;
   logic [7:0]           flash_data;
   logic                 flash_data_ready;
   logic                 flash_busy;

   // The prefetch buffer itself
   modport slave (
      input  rom_read, rom_address, flash_data, flash_data_ready, flash_busy,
      output rom_data, rom_wait, flash_addr, flash_start_read, flash_stop_read,
             flash_stall_read
   );

   // CPU bus plus flash controller surrounding the buffer
   modport master (
      output rom_read, rom_address, flash_data, flash_data_ready, flash_busy,
      input  rom_data, rom_wait, flash_addr, flash_start_read, flash_stop_read,
             flash_stall_read
   );
endinterface
`default_nettype wire

// File: rtl/rom_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rom_prefetch_buffer
// Brief    : Ring-buffered byte window over a sequential QSPI read stream
// Revision : 1.0 - initial release
// ============================================================================
module rom_prefetch_buffer #(
   parameter int DEPTH     = 4,
   parameter int ADDR_BITS = 12
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   rom_prefetch_buffer_if.slave   bus
);
   localparam int c_ptr_bits = $clog2(DEPTH);
   localparam int c_cnt_bits = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_STREAM = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_BITS-1:0]  r_base, r_flash_addr;
   logic [c_cnt_bits-1:0] r_count;
   logic [c_ptr_bits-1:0] r_rd_ptr, r_wr_ptr;
   logic [7:0]            r_slot [DEPTH];
   logic [7:0]            r_rom_data;
   logic                  r_start, r_stop, r_ready_d;

   logic [ADDR_BITS-1:0]  w_k;
   logic [c_cnt_bits-1:0] w_k_cnt;
   logic [c_ptr_bits-1:0] w_rd_idx;
   logic                  w_hit, w_pending, w_miss, w_streaming, w_full, w_capture;
   logic                  w_restart, w_clear, w_start_nxt, w_stop_nxt;

   assign w_k         = bus.rom_address - r_base;
   assign w_streaming = (r_state == S_START) || (r_state == S_STREAM);
   assign w_hit       = bus.rom_read && (w_k < ADDR_BITS'(r_count));
   assign w_pending   = bus.rom_read && (w_k == ADDR_BITS'(r_count)) && w_streaming;
   assign w_miss      = bus.rom_read && !w_hit && !w_pending;
   assign w_k_cnt     = w_hit ? w_k[c_cnt_bits-1:0] : '0;
   assign w_rd_idx    = r_rd_ptr + w_k[c_ptr_bits-1:0];
   assign w_full      = (r_count == c_cnt_bits'(DEPTH));
   // A full ring may still accept a byte when the same-cycle hit frees a slot
   assign w_capture   = w_streaming && bus.flash_data_ready && !r_ready_d &&
                        (!w_full || (w_k_cnt != '0));

   assign bus.rom_wait         = bus.rom_read && !w_hit;
   assign bus.rom_data         = r_rom_data;
   assign bus.flash_addr       = r_flash_addr;
   assign bus.flash_start_read = r_start;
   assign bus.flash_stop_read  = r_stop;
   assign bus.flash_stall_read = w_full && (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_clear     = 1'b0;
      w_start_nxt = 1'b0;
      w_stop_nxt  = 1'b0;
      case (r_state)
         S_IDLE: if (w_miss) begin
            w_restart   = 1'b1;
            w_start_nxt = 1'b1;
            w_state_nxt = S_START;
         end
         // A miss seen here is left alone until the stream is running
         S_START: if (bus.flash_busy) w_state_nxt = S_STREAM;
         S_STREAM: if (w_miss) begin
            w_stop_nxt  = 1'b1;
            w_state_nxt = S_STOP;
         end
         S_STOP: if (!bus.flash_busy) begin
            w_clear     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base       <= '0;
         r_flash_addr <= '0;
         r_count      <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_rom_data   <= 8'h00;
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_ready_d    <= 1'b0;
      end else begin
         r_start   <= w_start_nxt;
         r_stop    <= w_stop_nxt;
         r_ready_d <= bus.flash_data_ready;
         if (w_hit) r_rom_data <= r_slot[w_rd_idx];
         if (w_restart) begin
            r_base       <= bus.rom_address;
            r_flash_addr <= bus.rom_address;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
         end else begin
            if (w_hit) begin
               r_base   <= r_base + w_k;
               r_rd_ptr <= w_rd_idx;
            end
            if (w_capture) r_wr_ptr <= r_wr_ptr + c_ptr_bits'(1);
            if (w_clear) r_count <= '0;
            else         r_count <= r_count + c_cnt_bits'(w_capture) - w_k_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) r_slot[r_wr_ptr] <= bus.flash_data;
   end
endmodule
`default_nettype wire

// File: tb/tb_rom_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_prefetch_buffer
// Brief    : Directed bench with a behavioural QSPI stream model and flash image
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_prefetch_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   int          m_budget = 1000;
   int          m_gap = 0;
   int          m_stop_cnt = 0;
   logic        m_active = 1'b0;
   logic [11:0] m_addr = '0;

   int          n_start = 0;
   int          n_stop = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          stop_cyc = 0;
   logic [11:0] last_start_addr = '0;
   logic        overlap = 1'b0;

   rom_prefetch_buffer_if #(.ADDR_BITS(12)) bus ();

   rom_prefetch_buffer #(.DEPTH(4), .ADDR_BITS(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] img(input logic [11:0] a);
      return (a[7:0] * 8'd13) ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Flash controller model: one-cycle ready pulses separated by a low cycle
   always begin
      @(posedge clk); #1;
      if (!rst_n) begin
         bus.flash_busy = 1'b0; bus.flash_data_ready = 1'b0;
         m_active = 1'b0; m_stop_cnt = 0;
      end else if (bus.flash_stop_read) begin
         m_active = 1'b0; bus.flash_data_ready = 1'b0; m_stop_cnt = 2;
      end else if (m_stop_cnt > 0) begin
         m_stop_cnt--;
         if (m_stop_cnt == 0) bus.flash_busy = 1'b0;
      end else if (bus.flash_start_read) begin
         m_active = 1'b1; m_addr = bus.flash_addr; bus.flash_busy = 1'b1;
         m_gap = 2; bus.flash_data_ready = 1'b0;
      end else if (m_active) begin
         if (bus.flash_data_ready) bus.flash_data_ready = 1'b0;
         else if (m_gap > 0) m_gap--;
         else if (!bus.flash_stall_read && m_budget > 0) begin
            bus.flash_data = img(m_addr);
            m_addr++;
            m_budget--;
            bus.flash_data_ready = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (bus.flash_start_read) begin
            n_start++; start_cyc = cyc; last_start_addr = bus.flash_addr;
         end
         if (bus.flash_stop_read) begin
            n_stop++; stop_cyc = cyc;
         end
         if (bus.flash_start_read && bus.flash_stop_read) overlap = 1'b1;
      end
   end

   // Leaves the caller at 1 time unit after a rising edge
   task automatic reset_dut();
      rst_n = 1'b0;
      bus.rom_read = 1'b0;
      bus.rom_address = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_budget = 1000;
      n_start = 0;
      n_stop = 0;
   endtask

   task automatic cpu_read(input logic [11:0] a);
      logic got_it;
      got_it = 1'b0;
      bus.rom_read = 1'b1;
      bus.rom_address = a;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!bus.rom_wait) begin
            got_it = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("read_wait_bound", 32'(got_it), 32'd1);
      @(posedge clk); #1;
      check($sformatf("data@%03h", a), 32'(bus.rom_data), 32'(img(a)));
   endtask

   task automatic wait_stall();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.flash_stall_read) begin
            seen = 1'b1;
            break;
         end
      end
      check("stall_set", 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic held;
      logic seen;
      bus.rom_read = 1'b0;
      bus.rom_address = '0;
      bus.flash_data = '0;
      bus.flash_data_ready = 1'b0;
      bus.flash_busy = 1'b0;

      // Asynchronous reset mid-stream with three bytes held
      reset_dut();
      m_budget = 3;
      cpu_read(12'h050);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_rom_data", 32'(bus.rom_data), 32'h00);
      check("rst_flash_addr", 32'(bus.flash_addr), 32'h000);
      check("rst_start", 32'(bus.flash_start_read), 32'd0);
      check("rst_stop", 32'(bus.flash_stop_read), 32'd0);
      check("rst_stall", 32'(bus.flash_stall_read), 32'd0);
      check("rst_wait", 32'(bus.rom_wait), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_budget = 1000;
      @(negedge clk);
      check("post_rst_miss_wait", 32'(bus.rom_wait), 32'd1);
      @(posedge clk); #1;
      check("post_rst_start", 32'(bus.flash_start_read), 32'd1);
      check("post_rst_addr", 32'(bus.flash_addr), 32'h050);

      // Sequential run
      reset_dut();
      for (int a = 12'h100; a <= 12'h107; a++) cpu_read(12'(a));
      check("seq_starts", 32'(n_start), 32'd1);
      check("seq_addr", 32'(last_start_addr), 32'h100);
      check("seq_stops", 32'(n_stop), 32'd0);

      // Full stall and release by a k=2 hit
      reset_dut();
      cpu_read(12'h100);
      bus.rom_read = 1'b0;
      wait_stall();
      bus.rom_read = 1'b1;
      bus.rom_address = 12'h102;
      @(negedge clk);
      check("stall_hit_wait", 32'(bus.rom_wait), 32'd0);
      @(posedge clk); #1;
      check("stall_hit_data", 32'(bus.rom_data), 32'(img(12'h102)));
      check("stall_released", 32'(bus.flash_stall_read), 32'd0);

      // Branch miss out of a full window
      reset_dut();
      cpu_read(12'h200);
      bus.rom_read = 1'b0;
      wait_stall();
      n_start = 0;
      n_stop = 0;
      bus.rom_read = 1'b1;
      bus.rom_address = 12'h380;
      @(negedge clk);
      check("branch_wait", 32'(bus.rom_wait), 32'd1);
      @(posedge clk); #1;
      cpu_read(12'h380);
      check("branch_stops", 32'(n_stop), 32'd1);
      check("branch_starts", 32'(n_start), 32'd1);
      check("branch_addr", 32'(last_start_addr), 32'h380);
      check("branch_order", 32'(start_cyc > stop_cyc), 32'd1);

      // Pending byte: base+count requested while the stream is held
      reset_dut();
      m_budget = 2;
      cpu_read(12'h300);
      repeat (10) @(posedge clk);
      #1;
      bus.rom_address = 12'h302;
      held = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (!bus.rom_wait) held = 1'b0;
      end
      check("pend_held", 32'(held), 32'd1);
      check("pend_no_stop", 32'(n_stop), 32'd0);
      @(posedge clk); #1;
      m_budget = 1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.flash_data_ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("pend_byte_seen", 32'(seen), 32'd1);
      check("pend_wait_before", 32'(bus.rom_wait), 32'd1);
      @(negedge clk);
      check("pend_wait_after", 32'(bus.rom_wait), 32'd0);
      @(posedge clk); #1;
      check("pend_data", 32'(bus.rom_data), 32'(img(12'h302)));
      check("pend_stops", 32'(n_stop), 32'd0);
      check("pend_starts", 32'(n_start), 32'd1);

      // Address wrap across the top of the space
      reset_dut();
      cpu_read(12'hFFE);
      cpu_read(12'hFFF);
      cpu_read(12'h000);
      cpu_read(12'h001);
      check("wrap_starts", 32'(n_start), 32'd1);
      check("wrap_addr", 32'(last_start_addr), 32'hFFE);
      check("wrap_stops", 32'(n_stop), 32'd0);

      check("start_stop_exclusive", 32'(overlap), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
